// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver for NUM_DIGITS
// 7-segment digits that share one segment bus.
// A loaded word waits in a pending register and is copied into the display
// shadow only when the scan wraps, so a frame never mixes two values.
// Optional feature macro: SEG7_BLINK_EN adds blink_mask and BLINK_FRAMES.
//
// Handshake: load is a plain 1-cycle strobe with no ready; every cycle with
// load=1 captures value_in, and the latest capture before a wrap wins.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   digit_en,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    tc, wrap, fd_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, shadow_q;
  logic                    pend_flag_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_done_q;
  logic [NUM_DIGITS-1:0]   lz_vec, blank_vec;
  logic                    zero_above;
  logic [3:0]              nib;
  logic                    cur_blank;
  logic                    blink_phase;

  // Active-low decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Divider/index next state; frame_done is registered one cycle early so it
  // is high exactly during the wrap cycle.
  always_comb begin
    tc    = (div_q == DIV_LAST);
    wrap  = tc && (idx_q == IDX_LAST);
    div_d = tc ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    fd_d  = (div_d == DIV_LAST) && (idx_d == IDX_LAST);
  end

  // Per-digit blanking: leading zeros (never digit 0), enable mask, blink.
  always_comb begin
    lz_vec     = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (shadow_q[4*i +: 4] == 4'h0);
      lz_vec[i]  = zero_above;
    end
    lz_vec[0] = 1'b0;
    blank_vec = ~digit_en | ({NUM_DIGITS{lz_blank}} & lz_vec);
`ifdef SEG7_BLINK_EN
    blank_vec = blank_vec | ({NUM_DIGITS{blink_phase}} & blink_mask);
`endif
  end

  // Output next state for the digit currently addressed by the index.
  always_comb begin
    nib       = shadow_q[{idx_q, 2'b00} +: 4];
    cur_blank = blank_vec[idx_q];
    seg_d     = cur_blank ? 7'h7F : hex_to_seg(nib);
    dig_d     = '1;
    if (!cur_blank) dig_d[idx_q] = 1'b0;
  end

  // Scan timing and registered outputs; reset aborts the scan at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= 7'h7F;
      dig_q        <= '1;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      frame_done_q <= fd_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  // Pending/shadow transfer; a load coinciding with the wrap bypasses pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_val_q  <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
    end else if (wrap) begin
      if (load) begin
        shadow_q   <= value_in;
        pend_val_q <= value_in;
      end else if (pend_flag_q) begin
        shadow_q   <= pend_val_q;
      end
      pend_flag_q <= 1'b0;
    end else if (load) begin
      pend_val_q  <= value_in;
      pend_flag_q <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] frame_cnt_q;

  // Count completed frames and flip the blink phase every BLINK_FRAMES.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_q <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end
`else
  assign blink_phase = 1'b0;
`endif

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with
// NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2. Blink checks need SEG7_BLINK_EN.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        lz_blank;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [10:0] exp_q[$];
  int          cyc;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .load      (load),
    .lz_blank  (lz_blank),
    .digit_en  (digit_en),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Step negedges until frame_done is seen (bounded); returns cycles stepped.
  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < 64);
    chk("frame_seen", {15'b0, frame_done}, 16'h1);
  endtask

  task automatic load_pulse(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Queue expected segments for digits 0..3; 7F means a blank slot.
  task automatic expect_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] d;
      d = 4'hF;
      if (s[k] != 7'h7F) d[k] = 1'b0;
      exp_q.push_back({d, s[k]});
    end
  endtask

  // Called from a wrap-cycle negedge (pre=2) or one cycle after it (pre=1).
  task automatic check_slots(input int pre);
    logic [10:0] e;
    repeat (pre) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
      chk($sformatf("seg_d%0d", k), {9'b0, seg_out}, {9'b0, e[6:0]});
      chk($sformatf("dig_d%0d", k), {12'b0, dig_sel}, {12'b0, e[10:7]});
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; value_in = '0; lz_blank = 1'b0;
    digit_en = 4'hF; blink_mask = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);

    // 1. async reset mid-scan, release, scan order and frame period
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_seg", {9'b0, seg_out}, 16'h007F);
    chk("rst_dig", {12'b0, dig_sel}, 16'h000F);
    chk("rst_fd", {15'b0, frame_done}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_dig", {12'b0, dig_sel}, 16'h000E);
    chk("rel_seg", {9'b0, seg_out}, 16'h0040);
    wait_frame(cyc);
    chk("first_frame_cycles", 16'(cyc), 16'd14);
    @(negedge clk);
    chk("fd_one_cycle", {15'b0, frame_done}, 16'h0);
    wait_frame(cyc);
    chk("frame_period", 16'(cyc), 16'd15);
    expect_frame(7'h40, 7'h40, 7'h40, 7'h40);
    check_slots(2);

    // 2. load mid-frame is held until the wrap
    wait_frame(cyc);
    repeat (3) @(negedge clk);
    load_pulse(16'h1A2F);
    chk("tear_free_seg", {9'b0, seg_out}, 16'h0040);
    expect_frame(7'h0E, 7'h24, 7'h08, 7'h79);
    wait_frame(cyc);
    check_slots(2);

    // 3. latest load wins; load coincident with the wrap bypasses
    wait_frame(cyc);
    repeat (3) @(negedge clk);
    load_pulse(16'h1111);
    load_pulse(16'h2222);
    expect_frame(7'h24, 7'h24, 7'h24, 7'h24);
    wait_frame(cyc);
    check_slots(2);
    wait_frame(cyc);
    load_pulse(16'h3456);
    expect_frame(7'h02, 7'h12, 7'h19, 7'h30);
    check_slots(1);

    // 4. leading-zero blanking, sampled live
    lz_blank = 1'b1;
    wait_frame(cyc);
    repeat (2) @(negedge clk);
    load_pulse(16'h0050);
    expect_frame(7'h40, 7'h12, 7'h7F, 7'h7F);
    wait_frame(cyc);
    check_slots(2);
    wait_frame(cyc);
    repeat (2) @(negedge clk);
    load_pulse(16'h0000);
    expect_frame(7'h40, 7'h7F, 7'h7F, 7'h7F);
    wait_frame(cyc);
    check_slots(2);
    lz_blank = 1'b0;
    expect_frame(7'h40, 7'h40, 7'h40, 7'h40);
    wait_frame(cyc);
    check_slots(2);

    // 5. digit enable mask
    digit_en = 4'b1010;
    wait_frame(cyc);
    repeat (2) @(negedge clk);
    load_pulse(16'h8888);
    expect_frame(7'h7F, 7'h00, 7'h7F, 7'h00);
    wait_frame(cyc);
    check_slots(2);
    digit_en = 4'hF;

`ifdef SEG7_BLINK_EN
    // 6. blink: d0 lit two frames, blank two frames, counted from reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    blink_mask = 4'b0001;
    @(negedge clk);
    load_pulse(16'h1234);
    for (int f = 1; f <= 6; f++) begin
      logic lit;
      lit = (f == 1) || (f == 4) || (f == 5);
      expect_frame(lit ? 7'h19 : 7'h7F, 7'h30, 7'h24, 7'h79);
      wait_frame(cyc);
      check_slots(2);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
